cim_mem_arb: RTL and testbench
==============================

# cim_mem_arb

Parametrised single-port CIM storage bank with built-in N-source arbitration. It replaces the one-hot-select, latch-addressed memory wrapper with a request/grant front end, registered read return tagged with the requesting source, per-source write protection and out-of-range detection. One instance serves intermediate results and one serves model parameters inside each CIM. Requesters are the bus FSM, the logic FSM and the MAC.

## Interface
Parameters:
- `N_SRC`, 3: number of requesters; index 0 = BUS_FSM, 1 = LOGIC_FSM, 2 = MAC.
- `DATA_W`, 16: word width (`N_STORAGE`).
- `DEPTH`, 528: words stored; `AW = $clog2(DEPTH)`.
- `WR_MASK`, 3'b011: bit i = 1 means source i may write.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_SRC  per-source access request.
- `we`  in  N_SRC  per-source write enable (1 = write, 0 = read), qualified by `req`.
- `addr`  in  N_SRC*AW  packed addresses; source i at `[i*AW +: AW]`.
- `wdata`  in  N_SRC*DATA_W  packed write data; source i at `[i*DATA_W +: DATA_W]`.
- `gnt`  out  N_SRC  one-hot grant, combinational, same cycle as `req`.
- `rdata`  out  DATA_W  registered read data.
- `rvalid`  out  1  `rdata` carries a fresh read result this cycle.
- `rsrc`  out  N_SRC  one-hot source that issued the read now on `rdata`.
- `err_wr_prot`  out  1  one-cycle pulse: a granted write from a protected source was suppressed.
- `err_oob`  out  1  one-cycle pulse: a granted access had `addr >= DEPTH`.

## Operation
- Exactly one access per cycle. `gnt` is zero or one-hot, and is never set for a source whose `req` = 0.
- Arbitration default (macro off) is fixed priority: lowest requesting index wins.
- Handshake: a requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. The access is consumed on the edge where `req & gnt` = 1. A requester may drop `req` before it is granted; nothing happens in that case.
- Granted write, allowed source, in range: `mem[addr] <= wdata` at that edge. No read result is produced: `rvalid` = 0 next cycle and `rdata` holds its value.
- Granted write, source bit 0 in `WR_MASK`: memory is unchanged and `err_wr_prot` = 1 next cycle. The request still counts as consumed.
- Granted read, in range: `rdata <= mem[addr]`, `rvalid <= 1`, `rsrc <= gnt`.
- Granted access with `addr >= DEPTH`:
  - a write is dropped;
  - a read returns `rdata = 0` with `rvalid = 1`;
  - `err_oob` = 1 next cycle.
- Protect and out-of-range on the same write: both error flags pulse.
- No grant in a cycle: `rvalid <= 0`, `rsrc <= 0`, `rdata` holds its value. No latches anywhere.
- Reset:
  - `rdata`, `rvalid`, `rsrc`, `err_wr_prot` and `err_oob` go to 0.
  - The round-robin pointer goes to 0.
  - `gnt` is forced to 0 while `rst` = 1.
  - Memory contents are not reset.
  - An access presented in the reset cycle is discarded.

## Timing
- Grant latency 0 cycles (combinational from `req`).
- Read latency 1 cycle: grant at edge k, `rdata`/`rvalid`/`rsrc` valid after edge k, for one cycle.
- Back-to-back reads from any mix of sources sustain one result per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data (write lands at edge k, read samples at edge k+1).
- Error flags are registered and appear 1 cycle after the offending grant.
- A losing requester stalls with no bound under fixed priority. Round-robin bounds the wait to N_SRC-1 cycles.

## Configuration
- `CIM_MEM_ARB_RR_EN` defined:
  - round-robin arbitration; a pointer register holds the index after the last granted source;
  - the search starts at the pointer and wraps modulo N_SRC;
  - the pointer updates only on a grant.
- Undefined: fixed priority (index 0 highest) and no pointer register.
- Datapath, latency and error behaviour are identical in both builds.

## Test plan
- Reset, then source 0 writes 0xBEEF to addr 5, then source 1 reads addr 5 → next cycle `rdata` = 0xBEEF, `rvalid` = 1, `rsrc` = 3'b010.
- All three sources request reads (addr 1/2/3) for 3 cycles:
  - macro off: grants 001, 001, 001;
  - macro on: grants 001, 010, 100, and `rsrc` follows one cycle later.
- Source 2 (MAC) writes 0x1234 to addr 7 → `gnt` = 3'b100, `err_wr_prot` pulses 1 cycle, and a later read of addr 7 returns the prior value.
- Source 0 reads addr 600 (≥ DEPTH) → `rvalid` = 1, `rdata` = 0, `err_oob` = 1 for one cycle. Source 0 writes to addr 600 → no memory change, `err_oob` pulses.
- Assert `rst` in the cycle after a granted read of addr 5 → `rvalid`, `rsrc` and `rdata` are 0 after that edge. Addr 5 still reads 0xBEEF after reset.
- Throughput check: source 1 issues reads of addr 0..15 every cycle → 16 consecutive `rvalid` pulses with the correct data and no gaps.

Source files
------------

// File: rtl/cim_mem_arb_if.sv
// Request/grant bus between the CIM requesters (bus FSM, logic FSM, MAC) and one
// cim_mem_arb storage bank. Per-source fields are packed, source i at slice i.
interface cim_mem_arb_if #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 16,
  parameter int AW     = 10
);
  logic [N_SRC-1:0]        req;
  logic [N_SRC-1:0]        we;
  logic [N_SRC*AW-1:0]     addr;
  logic [N_SRC*DATA_W-1:0] wdata;
  logic [N_SRC-1:0]        gnt;
  logic [DATA_W-1:0]       rdata;
  logic                    rvalid;
  logic [N_SRC-1:0]        rsrc;
  logic                    err_wr_prot;
  logic                    err_oob;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid, rsrc, err_wr_prot, err_oob
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid, rsrc, err_wr_prot, err_oob
  );
endinterface

// File: rtl/cim_mem_arb.sv
// Single-port CIM storage bank with N-source arbitration, tagged registered reads,
// per-source write protection and out-of-range detection. Define CIM_MEM_ARB_RR_EN for round-robin.
module cim_mem_arb #(
  parameter int               N_SRC   = 3,
  parameter int               DATA_W  = 16,
  parameter int               DEPTH   = 528,
  parameter logic [N_SRC-1:0] WR_MASK = 3'b011
) (
  input  logic         clk,
  input  logic         rst,
  cim_mem_arb_if.slave bus
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             PW      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [AW:0]    DEPTH_X = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [N_SRC-1:0]  gnt;
  logic              any_gnt;
  logic [PW-1:0]     sel_idx;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic              wr_allowed;
  logic              mem_wr_en;

  logic [DATA_W-1:0] rdata_d,  rdata_q;
  logic              rvalid_d, rvalid_q;
  logic [N_SRC-1:0]  rsrc_d,   rsrc_q;
  logic              prot_d,   prot_q;
  logic              oob_d,    oob_q;

`ifdef CIM_MEM_ARB_RR_EN
  logic [PW-1:0]     ptr_d, ptr_q;

  function automatic int wrap_idx(input int base, input int ofs);
    return (base + ofs) % N_SRC;
  endfunction
`endif

  // Arbitration: at most one one-hot grant, never to an idle source, none during reset
  always_comb begin
    gnt     = '0;
    any_gnt = 1'b0;
    sel_idx = '0;
`ifdef CIM_MEM_ARB_RR_EN
    for (int k = 0; k < N_SRC; k++) begin
      if (!any_gnt && bus.req[wrap_idx(int'(ptr_q), k)]) begin
        any_gnt                        = 1'b1;
        gnt[wrap_idx(int'(ptr_q), k)]  = 1'b1;
        sel_idx                        = PW'(wrap_idx(int'(ptr_q), k));
      end
    end
`else
    for (int i = 0; i < N_SRC; i++) begin
      if (!any_gnt && bus.req[i]) begin
        any_gnt = 1'b1;
        gnt[i]  = 1'b1;
        sel_idx = PW'(i);
      end
    end
`endif
    if (rst) begin
      gnt     = '0;
      any_gnt = 1'b0;
    end
  end

  assign bus.gnt = gnt;

  // Winner's request fields
  always_comb begin
    sel_we     = bus.we[sel_idx];
    sel_addr   = bus.addr[int'(sel_idx)*AW +: AW];
    sel_wdata  = bus.wdata[int'(sel_idx)*DATA_W +: DATA_W];
    in_range   = ({1'b0, sel_addr} < DEPTH_X);
    wr_allowed = WR_MASK[sel_idx];
    mem_wr_en  = any_gnt && sel_we && wr_allowed && in_range;
  end

  // Next-state for the read return and error pulses
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rsrc_d   = '0;
    prot_d   = 1'b0;
    oob_d    = 1'b0;
    if (any_gnt) begin
      oob_d = !in_range;
      if (sel_we) begin
        prot_d = !wr_allowed;
      end else begin
        rvalid_d = 1'b1;
        rsrc_d   = gnt;
        rdata_d  = in_range ? mem_q[sel_addr] : '0;
      end
    end
  end

  // Storage array: never reset, written only by permitted in-range grants
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem_q[sel_addr] <= sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rsrc_q   <= '0;
      prot_q   <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rsrc_q   <= rsrc_d;
      prot_q   <= prot_d;
      oob_q    <= oob_d;
    end
  end

`ifdef CIM_MEM_ARB_RR_EN
  // Pointer holds the index after the last winner and moves only on a grant
  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) begin
      ptr_d = PW'(wrap_idx(int'(sel_idx), 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign bus.rdata       = rdata_q;
  assign bus.rvalid      = rvalid_q;
  assign bus.rsrc        = rsrc_q;
  assign bus.err_wr_prot = prot_q;
  assign bus.err_oob     = oob_q;

endmodule

// File: tb/tb_cim_mem_arb.sv
// Self-checking bench for cim_mem_arb: a reference model predicts grants, error pulses
// and read returns; read results are queued at grant time and popped when rvalid appears.
module tb_cim_mem_arb;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  src;
  } rd_t;

  logic clk = 1'b0;
  logic rst;

  cim_mem_arb_if #(.N_SRC(3), .DATA_W(16), .AW(10)) bus ();

  cim_mem_arb #(
    .N_SRC  (3),
    .DATA_W (16),
    .DEPTH  (528),
    .WR_MASK(3'b011)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_rv  = 0;
  int          ptr_m = 0;
  logic [15:0] mem_m [int];
  logic [15:0] exp_rdata = '0;
  logic [2:0]  wr_mask = 3'b011;
  logic [2:0]  g_obs;
  logic [2:0]  g4 [3];
  rd_t         sb [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check grant, predict, check after rising edge
  task automatic step(input logic [2:0] r, input logic [2:0] w,
                      input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                      input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    logic [9:0]  aa [3];
    logic [15:0] dd [3];
    logic [2:0]  eg;
    logic [9:0]  ga;
    logic        ep, eo, erv;
    int          gi;
    rd_t         ent;
    rd_t         got;
    aa[0] = a0; aa[1] = a1; aa[2] = a2;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    bus.req   = r;
    bus.we    = w;
    bus.addr  = {a2, a1, a0};
    bus.wdata = {d2, d1, d0};
    #1;
    gi = -1;
    if (!rst) begin
`ifdef CIM_MEM_ARB_RR_EN
      for (int k = 0; k < 3; k++) begin
        if (gi < 0 && r[(ptr_m + k) % 3]) gi = (ptr_m + k) % 3;
      end
`else
      for (int k = 0; k < 3; k++) begin
        if (gi < 0 && r[k]) gi = k;
      end
`endif
    end
    eg = '0;
    if (gi >= 0) eg[gi] = 1'b1;
    g_obs = bus.gnt;
    chk("gnt", {29'd0, bus.gnt}, {29'd0, eg});
    ep = 1'b0; eo = 1'b0; erv = 1'b0;
    if (rst) begin
      ptr_m     = 0;
      exp_rdata = '0;
      sb.delete();
    end else if (gi >= 0) begin
      ga    = aa[gi];
      eo    = (ga >= 10'd528);
      ptr_m = (gi + 1) % 3;
      if (w[gi]) begin
        ep = !wr_mask[gi];
        if (!ep && !eo) mem_m[int'(ga)] = dd[gi];
      end else begin
        erv      = 1'b1;
        ent.data = eo ? 16'h0 : (mem_m.exists(int'(ga)) ? mem_m[int'(ga)] : 16'h0);
        ent.src  = eg;
        sb.push_back(ent);
        exp_rdata = ent.data;
      end
    end
    @(posedge clk);
    #1;
    chk("err_wr_prot", {31'd0, bus.err_wr_prot}, {31'd0, ep});
    chk("err_oob", {31'd0, bus.err_oob}, {31'd0, eo});
    chk("rvalid", {31'd0, bus.rvalid}, {31'd0, erv});
    if (bus.rvalid) begin
      n_rv++;
      chk("sb_size", sb.size(), 1);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        chk("rdata_ret", {16'd0, bus.rdata}, {16'd0, got.data});
        chk("rsrc", {29'd0, bus.rsrc}, {29'd0, got.src});
      end
    end else begin
      chk("rsrc_idle", {29'd0, bus.rsrc}, 32'd0);
    end
    chk("rdata_hold", {16'd0, bus.rdata}, {16'd0, exp_rdata});
    @(negedge clk);
  endtask

  task automatic idle();
    step(3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    @(negedge clk);
    // Access during reset must be discarded
    step(3'b001, 3'b001, 10'd5, 10'd0, 10'd0, 16'hDEAD, 16'h0, 16'h0);
    step(3'b010, 3'b000, 10'd0, 10'd5, 10'd0, 16'h0, 16'h0, 16'h0);
    chk("reset_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("reset_rdata", {16'd0, bus.rdata}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(3'b001, 3'b001, 10'(i), 10'd0, 10'd0, 16'h0100 + 16'(i), 16'h0, 16'h0);
    end
    step(3'b001, 3'b001, 10'd7, 10'd0, 10'd0, 16'h0777, 16'h0, 16'h0);

    step(3'b001, 3'b001, 10'd5, 10'd0, 10'd0, 16'hBEEF, 16'h0, 16'h0);
    step(3'b010, 3'b000, 10'd0, 10'd5, 10'd0, 16'h0, 16'h0, 16'h0);
    chk("tp_beef_rdata", {16'd0, bus.rdata}, 32'h0000BEEF);
    chk("tp_beef_rsrc", {29'd0, bus.rsrc}, 32'd2);
    chk("tp_beef_rvalid", {31'd0, bus.rvalid}, 32'd1);

    // Realign the round-robin pointer, then three-way contention
    rst = 1'b1;
    idle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(3'b111, 3'b000, 10'd1, 10'd2, 10'd3, 16'h0, 16'h0, 16'h0);
      g4[c] = g_obs;
    end
`ifdef CIM_MEM_ARB_RR_EN
    chk("tp_rr_g0", {29'd0, g4[0]}, 32'd1);
    chk("tp_rr_g1", {29'd0, g4[1]}, 32'd2);
    chk("tp_rr_g2", {29'd0, g4[2]}, 32'd4);
`else
    chk("tp_fp_g0", {29'd0, g4[0]}, 32'd1);
    chk("tp_fp_g1", {29'd0, g4[1]}, 32'd1);
    chk("tp_fp_g2", {29'd0, g4[2]}, 32'd1);
`endif

    step(3'b100, 3'b100, 10'd0, 10'd0, 10'd7, 16'h0, 16'h0, 16'h1234);
    chk("tp_prot_flag", {31'd0, bus.err_wr_prot}, 32'd1);
    idle();
    step(3'b010, 3'b000, 10'd0, 10'd7, 10'd0, 16'h0, 16'h0, 16'h0);
    chk("tp_prot_keep", {16'd0, bus.rdata}, 32'h00000777);

    step(3'b001, 3'b000, 10'd600, 10'd0, 10'd0, 16'h0, 16'h0, 16'h0);
    chk("tp_oob_rdata", {16'd0, bus.rdata}, 32'd0);
    chk("tp_oob_flag", {31'd0, bus.err_oob}, 32'd1);
    step(3'b001, 3'b001, 10'd600, 10'd0, 10'd0, 16'hAAAA, 16'h0, 16'h0);
    chk("tp_oob_wr_flag", {31'd0, bus.err_oob}, 32'd1);
    step(3'b100, 3'b100, 10'd0, 10'd0, 10'd600, 16'h0, 16'h0, 16'h5555);
    chk("tp_both_prot", {31'd0, bus.err_wr_prot}, 32'd1);
    chk("tp_both_oob", {31'd0, bus.err_oob}, 32'd1);
    idle();

    // Reset right after a granted read clears the return registers, not the memory
    step(3'b001, 3'b000, 10'd5, 10'd0, 10'd0, 16'h0, 16'h0, 16'h0);
    rst = 1'b1;
    step(3'b001, 3'b000, 10'd5, 10'd0, 10'd0, 16'h0, 16'h0, 16'h0);
    chk("tp_rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("tp_rst_rdata", {16'd0, bus.rdata}, 32'd0);
    rst = 1'b0;
    step(3'b001, 3'b000, 10'd5, 10'd0, 10'd0, 16'h0, 16'h0, 16'h0);
    chk("tp_rst_mem", {16'd0, bus.rdata}, 32'h0000BEEF);

    n_rv = 0;
    for (int i = 0; i < 16; i++) begin
      step(3'b010, 3'b000, 10'd0, 10'(i), 10'd0, 16'h0, 16'h0, 16'h0);
    end
    chk("tp_throughput", n_rv, 16);

    for (int c = 0; c < 60; c++) begin
      step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 9) == 0) ? 10'd600 : 10'($urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0) ? 10'd600 : 10'($urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0) ? 10'd600 : 10'($urandom_range(0, 15)),
           16'($urandom), 16'($urandom), 16'($urandom));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
